cpu_seq_ctrl: RTL

Program sequencer for the `cpu` execution core. It holds a host-loadable program store and feeds one instruction per cycle to the core, addressed by the core's own `cmd_id`. It captures `out` results into a ready/valid FIFO with backpressure, and provides start, halt, resume, a step watchdog and fault reporting. It sits between the host/bus bridge and the core; the core never sees the host directly.

---
 rtl/cpu_seq_pkg.sv | 15 +
 rtl/cpu_seq_fifo.sv | 38 +++
 rtl/cpu_seq_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: opcodes, sequencer states and core command layout shared by the cpu sequencer
package cpu_seq_pkg;
  localparam logic [7:0] OP_JMP = 8'd1;
  localparam logic [7:0] OP_OUT = 8'd18;
  localparam logic [7:0] OP_HALT = 8'hFF;
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, PAUSED, DONE, FAULT} seq_state_t;
  typedef struct packed {
    logic [7:0]  ext;
    logic [15:0] arg;
    logic [7:0]  op;
  } cmd_t;
  function automatic cmd_t jmp_cmd(input logic [15:0] addr);
    return '{ext: 8'h00, arg: addr, op: OP_JMP};
  endfunction
endpackage

// File: rtl/cpu_seq_fifo.sv
// cpu_seq_fifo: first-word fall-through FIFO that accepts a push into a full queue when a pop happens alongside
module cpu_seq_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(2**AW);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = empty ? '0 : mem[rptr];
  // Storage array, written at the tail
  always_ff @(posedge sys_clk)
    if (do_push) mem[wptr] <= wdata;
  // Pointers and occupancy
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: program sequencer and result capture for the cpu core; define CPU_SEQ_BKPT_EN to add a breakpoint
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int PROG_AW = 8,
  parameter int RES_AW = 4,
  parameter int STEP_W = 24
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               prog_we,
  input  logic [PROG_AW-1:0] prog_addr,
  input  logic [31:0]        prog_wdata,
  input  logic               start,
  input  logic [15:0]        start_addr,
  input  logic               halt_req,
  input  logic               resume,
  input  logic [STEP_W-1:0]  step_limit,
`ifdef CPU_SEQ_BKPT_EN
  input  logic [15:0]        bkpt_addr,
  input  logic               bkpt_valid,
`endif
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [STEP_W-1:0]  step_cnt,
  output logic [31:0]        core_cmd,
  output logic               core_cmd_en,
  input  logic [15:0]        core_cmd_id,
  input  logic [31:0]        core_res,
  output logic               res_valid,
  output logic [31:0]        res_data,
  input  logic               res_ready,
  output logic               res_ovf
);
  seq_state_t state;
  logic [31:0] prog_mem [2**PROG_AW];
  cmd_t fetch;
  logic out_pend, oor, is_halt, is_out, wdog, bkpt_hit, slot_free, can_write, fifo_full, fifo_empty;
  logic [RES_AW:0] fifo_count;
  assign fetch = prog_mem[core_cmd_id[PROG_AW-1:0]];
  assign oor = (core_cmd_id >> PROG_AW) != 16'd0;
  assign is_halt = fetch.op == OP_HALT;
  assign is_out = fetch.op == OP_OUT;
  assign wdog = step_limit != '0 && step_cnt == step_limit;
  assign slot_free = (fifo_count + (RES_AW+1)'(out_pend)) < (RES_AW+1)'(2**RES_AW);
  assign can_write = state == IDLE || state == DONE || state == FAULT;
  assign busy = state == LAUNCH || state == RUN || state == PAUSED;
  assign res_valid = !fifo_empty;
`ifdef CPU_SEQ_BKPT_EN
  logic bkpt_skip;
  // The first RUN cycle after a resume steps over the breakpoint it stopped on
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) bkpt_skip <= 1'b0;
    else bkpt_skip <= state == PAUSED && resume && !start;
  assign bkpt_hit = bkpt_valid && core_cmd_id == bkpt_addr && !bkpt_skip;
`else
  assign bkpt_hit = 1'b0;
`endif
  // Program store only accepts host writes while no program is in flight
  always_ff @(posedge sys_clk)
    if (prog_we && can_write) prog_mem[prog_addr] <= prog_wdata;
  // Sequencer FSM; LAUNCH already evaluates the first fetch so the jump target issues with no bubble
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      core_cmd <= '0;
      core_cmd_en <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      step_cnt <= '0;
      out_pend <= 1'b0;
    end else begin
      core_cmd_en <= 1'b0;
      out_pend <= 1'b0;
      if (start) begin
        state <= LAUNCH;
        core_cmd <= jmp_cmd(start_addr);
        core_cmd_en <= 1'b1;
        step_cnt <= '0;
        done <= 1'b0;
        fault <= 1'b0;
      end else if (state == LAUNCH || state == RUN) begin
        if (oor) begin
          state <= FAULT;
          fault <= 1'b1;
        end else if (is_halt) begin
          state <= DONE;
          done <= 1'b1;
        end else if (bkpt_hit) begin
          state <= PAUSED;
        end else if (wdog) begin
          state <= FAULT;
          fault <= 1'b1;
        end else if (halt_req) begin
          state <= PAUSED;
        end else if (!is_out || slot_free) begin
          state <= RUN;
          core_cmd <= fetch;
          core_cmd_en <= 1'b1;
          step_cnt <= step_cnt + STEP_W'(1);
          out_pend <= is_out;
        end else begin
          state <= RUN;
        end
      end else if (state == PAUSED && resume) begin
        state <= RUN;
      end
    end
  // Sticky flag for a push that found no room; issue stalls keep it low
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) res_ovf <= 1'b0;
    else if (out_pend && fifo_full && !(res_ready && res_valid)) res_ovf <= 1'b1;
  cpu_seq_fifo #(.DW(32), .AW(RES_AW)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (out_pend),
    .wdata     (core_res),
    .pop       (res_ready),
    .rdata     (res_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule
